// File: rtl/mult_pkg.sv
// Shared types and default sizing for the sequential multiplier.
package mult_pkg;

  localparam int unsigned DefWidth     = 32;
  localparam int unsigned DefProdWidth = 2 * DefWidth;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Execute-stage multiply request/response bundle between the pipeline and the multiplier.
interface mult_seq_ctrl_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);

  logic             aluormultE;
  logic             signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             abort;
  logic             prodv;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output aluormultE, signedE, srcaE, srcbE, abort,
    input  prodv, busy, hi, lo
  );

  modport slave (
    input  aluormultE, signedE, srcaE, srcbE, abort,
    output prodv, busy, hi, lo
  );

endinterface

// File: rtl/mult_shift_add.sv
// Shift-add datapath: magnitude operands, in-place accumulation, sign fix-up and HI/LO commit.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             commit_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  output logic             mplier_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    acc_next, prod;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             neg_q, neg_d;

  always_comb begin
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    abs_a    = (signed_i && srca_i[WIDTH-1]) ? (~srca_i + 1'b1) : srca_i;
    abs_b    = (signed_i && srcb_i[WIDTH-1]) ? (~srcb_i + 1'b1) : srcb_i;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = neg_q ? (~acc_next + 1'b1) : acc_next;

    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, abs_a};
      mplier_d = abs_b;
      neg_d    = signed_i & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
      acc_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end

    if (commit_i) begin
      {hi_d, lo_d} = prod;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Multiplier becomes zero after this cycle's shift.
  assign mplier_zero_o = ~|mplier_q[WIDTH-1:1];
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle multiply sequencer: IDLE -> BUSY (one multiplier bit per cycle) -> DONE pulse.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNTW  = 6
) (
  input  logic            clk,
  input  logic            reset,
  mult_seq_ctrl_if.slave  bus
);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic            prodv_q;
  logic            busy_q;

  logic             start, step, last, commit;
  logic             mplier_zero;
  logic [WIDTH-1:0] hi, lo;

  always_comb begin
    start  = (state_q == StIdle) && bus.aluormultE && !bus.abort;
    step   = (state_q == StBusy) && !bus.abort;
`ifdef MULT_EARLY_TERM_EN
    last   = (cnt_q == CNTW'(WIDTH - 1)) || mplier_zero;
`else
    last   = (cnt_q == CNTW'(WIDTH - 1));
`endif
    commit = step && last;
  end

`ifndef MULT_EARLY_TERM_EN
  logic unused_mplier_zero;
  assign unused_mplier_zero = mplier_zero;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prodv_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StBusy;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StBusy: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            prodv_q <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          // Abort is ignored here: the product is already committed.
          state_q <= StIdle;
          prodv_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          prodv_q <= 1'b0;
        end
      endcase
    end
  end

  mult_shift_add #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk           (clk),
    .reset         (reset),
    .load_i        (start),
    .step_i        (step),
    .commit_i      (commit),
    .signed_i      (bus.signedE),
    .srca_i        (bus.srcaE),
    .srcb_i        (bus.srcbE),
    .mplier_zero_o (mplier_zero),
    .hi_o          (hi),
    .lo_o          (lo)
  );

  assign bus.prodv = prodv_q;
  assign bus.busy  = busy_q;
  assign bus.hi    = hi;
  assign bus.lo    = lo;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencing controller plus iterative datapath for the multi-cycle multiplier in the execute stage.
- Accepts a multiply request while the instruction sits in E and runs a shift-add multiply, one multiplier bit per cycle.
- Commits the product to HI/LO and raises prodv so the hazard logic releases its mult stall (stall = request & ~prodv).
- Supports signed/unsigned operation, abort on pipeline flush, and HI/LO readout.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits, split into HI (upper) and LO (lower).
- CNTW, 6, width of the iteration counter; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- aluormultE  input  1  multiply request; held high while the mult instruction is in E.
- signedE  input  1  1 = signed multiply (mult), 0 = unsigned (multu); sampled at start.
- srcaE  input  WIDTH  multiplicand; sampled at start.
- srcbE  input  WIDTH  multiplier; sampled at start.
- abort  input  1  flush of the E-stage instruction; cancels an in-flight multiply.
- prodv  output  1  product valid; high exactly while state == DONE.
- busy  output  1  high while state == BUSY.
- hi  output  WIDTH  HI register (upper product half).
- lo  output  WIDTH  LO register (lower product half).

Behaviour:
- Reset (synchronous, active-high) takes effect on the next edge and overrides every other input, including mid-operation:
  - state = IDLE; prodv = 0, busy = 0; hi = 0, lo = 0; internal accumulators and counter = 0.
- States: IDLE, BUSY, DONE (encoding from package).
- IDLE:
  - If aluormultE & ~abort, latch the following, then go to BUSY:
    - mcand = |srcaE| zero-extended to 2*WIDTH.
    - mplier = |srcbE|.
    - neg = signedE & (srcaE[MSB] ^ srcbE[MSB]).
    - acc = 0, cnt = 0.
  - Absolute value is used only when signedE = 1; unsigned operands are taken as-is.
  - abort & aluormultE in the same cycle: abort wins, remain in IDLE.
- BUSY, each cycle:
  - acc_next = acc + (mplier[0] ? mcand : 0).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the final iteration (cnt == WIDTH-1):
    - Commit {hi, lo} = neg ? -acc_next : acc_next, modulo 2^(2*WIDTH).
    - Go to DONE.
- DONE:
  - prodv = 1 for exactly one cycle.
  - Unconditionally return to IDLE; the pipeline advances past the mult on this cycle.
  - A back-to-back mult arriving in E the next cycle starts from IDLE normally.
- Latency: request sampled in IDLE at edge t -> prodv high in cycle t+WIDTH+1. Default 33 cycles request-to-prodv, 34 total stall cycles.
- abort in BUSY:
  - Next edge returns to IDLE; hi/lo unchanged; prodv never asserted for that request.
- abort in DONE is ignored: the product is already committed.
- Signed corner case: -2^(WIDTH-1) * -2^(WIDTH-1) gives mcand = mplier = 2^(WIDTH-1) as an unsigned magnitude. The result 2^(2*WIDTH-2) must be exact.
- aluormultE deassertion mid-BUSY without abort is illegal (cannot occur under stall). Behaviour is undefined; the bench asserts against it.
- hi/lo change only on commit or reset.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - In BUSY, if mplier_next == 0 (after this cycle's shift), commit and go to DONE immediately.
  - Because the multiplicand-left-shift form accumulates in place, no residual shift is needed.
  - Latency becomes (index of highest set bit of |srcbE|) + 2 cycles to prodv, minimum 2 (e.g. multiplier 0 or 1).
- Undefined:
  - Fixed WIDTH iterations regardless of operand values.
  - Result values identical in both builds.

Decomposition:
- Package mult_pkg holds:
  - State enum {IDLE, BUSY, DONE}.
  - WIDTH default constant.
  - Product-width constant 2*WIDTH.
- One natural sub-module: mult_shift_add, holding mcand/mplier/acc registers and the add/shift/negate logic.
  - Controlled by load/step/commit strobes from the FSM in mult_seq_ctrl.
  - Flags mplier_zero back to the FSM.

Test Plan:
- Reset mid-BUSY (cycle 10 after start) -> next cycle IDLE, prodv = 0, hi = lo = 0; a fresh start then completes normally.
- Unsigned 0xFFFFFFFF * 0xFFFFFFFF, signedE = 0 -> prodv exactly 33 cycles after start; hi = 0xFFFFFFFE, lo = 0x00000001; prodv high 1 cycle.
- Signed -3 * 7 (0xFFFFFFFD, 0x00000007) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Signed 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
- abort asserted 5 cycles into BUSY after a prior product of 6 -> IDLE next cycle; hi/lo still 0/6; no prodv pulse. abort & aluormultE together in IDLE -> no start.
- Back-to-back: 2*3 then 4*5, aluormultE held across both -> two prodv pulses, each after its full latency (second pulse 34 cycles after the first); lo = 6 then 20.
- MULT_EARLY_TERM_EN defined: 123 * 1 -> prodv 2 cycles after start, lo = 123. 5 * 0 -> lo = 0 in 2 cycles. Same vectors undefined -> 33 cycles, identical results.
